// File: rtl/seg_scan_controller_pkg.sv
// seg_scan_controller_pkg
//   Definitions shared by the display blocks: a constant clog2 helper, a
//   minimum-width helper for counters and indices, anode polarity constants
//   and default refresh timing values.
package seg_scan_controller_pkg;

   localparam int DEFAULT_PRESCALE = 50000;
   localparam int DEFAULT_GUARD    = 2;

   localparam bit ANODE_POL_HIGH = 1'b0;  // active anode driven 1
   localparam bit ANODE_POL_LOW  = 1'b1;  // active anode driven 0

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Width of a counter/index that must hold 0..count-1, never below 1 bit.
   function automatic int min_width(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

endpackage

// File: rtl/seg_scan_controller_anode_decode.sv
// anode_decode
//   Combinational digit index + enable to one-hot anode drive with selectable
//   polarity. The parent registers the result.
// Ports
//   sel    in   SEL_W       digit index (0 = rightmost)
//   on     in   1           1 = drive the selected anode active
//   anode  out  NUM_DIGITS  one-hot (or none) anode pattern, polarity applied
module anode_decode
   import seg_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter bit ANODE_ACTIVE_LOW = ANODE_POL_HIGH,
   localparam int SEL_W           = min_width(NUM_DIGITS)
) (
   input  logic [SEL_W-1:0]      sel,
   input  logic                  on,
   output logic [NUM_DIGITS-1:0] anode
);

   logic [NUM_DIGITS-1:0] onehot;

   // Compare-based decode keeps out-of-range indices (non power-of-2 digit
   // counts) from ever selecting a bit.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         onehot[i] = on && (sel == SEL_W'(i));
      end
      anode = ANODE_ACTIVE_LOW ? ~onehot : onehot;
   end

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Multiplexed 7-segment digit scanner. Owns the refresh timebase, steps a
//   digit index through NUM_DIGITS slots and drives registered one-hot
//   anodes with a per-digit blanking mask, PWM brightness, an anti-ghost
//   guard window at the start of each slot and selectable anode polarity.
// Ports
//   clk         in   1           system clock, rising edge
//   rst         in   1           asynchronous reset, active-high
//   en          in   1           scan enable; 0 freezes timebase and blanks
//   digit_mask  in   NUM_DIGITS  1 = digit lit, 0 = digit blanked
//   bright      in   DUTY_BITS   duty level, captured at each slot advance
//   sel_out     out  SEL_W       index of the digit in its slot
//   anode       out  NUM_DIGITS  anode drive, polarity per ANODE_ACTIVE_LOW
//   slot_tick   out  1           pulse in first cycle of each new slot
//   frame_done  out  1           pulse in first cycle of slot 0 after a wrap
module seg_scan_controller
   import seg_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int PRESCALE         = DEFAULT_PRESCALE,
   parameter int GUARD            = DEFAULT_GUARD,
   parameter int DUTY_BITS        = 4,
   parameter bit ANODE_ACTIVE_LOW = ANODE_POL_HIGH,
   localparam int SEL_W           = min_width(NUM_DIGITS),
   localparam int PRE_W           = min_width(PRESCALE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NUM_DIGITS-1:0] digit_mask,
   input  logic [DUTY_BITS-1:0]  bright,
   output logic [SEL_W-1:0]      sel_out,
   output logic [NUM_DIGITS-1:0] anode,
   output logic                  slot_tick,
   output logic                  frame_done
);

   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [PRE_W-1:0]      GUARD_V  = PRE_W'(GUARD);
   localparam logic [SEL_W-1:0]      SEL_LAST = SEL_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_IDLE = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

   logic [PRE_W-1:0]      pre;
   logic [DUTY_BITS-1:0]  bright_q;

   logic                  advance;
   logic [PRE_W-1:0]      pre_nx;
   logic [SEL_W-1:0]      sel_nx;
   logic [DUTY_BITS-1:0]  bright_nx;
   logic                  mask_bit;
   logic                  duty_on;
   logic                  lit_nx;
   logic [NUM_DIGITS-1:0] anode_nx;

   // Next-state of the timebase. Registered outputs are derived from these
   // next values so anode/pulses line up with sel_out and pre in the same
   // cycle, with no one-cycle lag at slot edges.
   always_comb begin
      advance   = en && (pre == PRE_LAST);
      pre_nx    = pre;
      sel_nx    = sel_out;
      bright_nx = bright_q;
      if (en) begin
         pre_nx = advance ? '0 : pre + 1'b1;
      end
      if (advance) begin
         sel_nx    = (sel_out == SEL_LAST) ? '0 : sel_out + 1'b1;
         bright_nx = bright;
      end

      mask_bit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_nx == SEL_W'(i)) mask_bit = digit_mask[i];
      end

      // All-ones brightness must be fully on, which a plain "<" cannot express.
      duty_on = (bright_nx == '1) || (pre_nx[DUTY_BITS-1:0] < bright_nx);
      lit_nx  = en && mask_bit && (pre_nx >= GUARD_V) && duty_on;
   end

   anode_decode #(
      .NUM_DIGITS      (NUM_DIGITS),
      .ANODE_ACTIVE_LOW(ANODE_ACTIVE_LOW)
   ) u_anode_decode (
      .sel  (sel_nx),
      .on   (lit_nx),
      .anode(anode_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre        <= '0;
         sel_out    <= '0;
         bright_q   <= '0;
         anode      <= ANODE_IDLE;
         slot_tick  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pre        <= pre_nx;
         sel_out    <= sel_nx;
         bright_q   <= bright_nx;
         anode      <= anode_nx;
         slot_tick  <= advance;
         frame_done <= advance && (sel_nx == '0);
      end
   end

endmodule
